hazard_ctrl: RTL

//  Pipeline controller for the 5-stage core. Sequences the IF/ID and ID/EX pipeline registers.

---
 rtl/hazard_ctrl_pkg.sv | 37 +++
 rtl/hazard_cmp.sv | 30 +++
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: forwarding select
//   codes, controller state encoding and the register-match helper used by the
//   hazard comparators.
//   Configuration macro: HAZARD_FWD_EN (see hazard_ctrl.sv).
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    // Operand source selects for the ID operand muxes.
    localparam logic [1:0] FWD_RF  = 2'd0;  // register file
    localparam logic [1:0] FWD_EX  = 2'd1;  // EX result
    localparam logic [1:0] FWD_MEM = 2'd2;  // MEM result
    localparam logic [1:0] FWD_WB  = 2'd3;  // WB write data

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_LU  = 2'd1,
        ST_FRZ = 2'd2
    } state_e;

    // x0 is hard-wired zero, so a write to it can never create a dependency.
    function automatic logic reg_match(input logic [4:0] rs, input logic used,
                                       input logic [4:0] rd, input logic we);
        return used && we && (rd != 5'd0) && (rs == rd);
    endfunction

    // Youngest producer wins: EX holds newer data than MEM, MEM newer than WB.
    function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem,
                                            input logic hit_wb);
        if (hit_ex)       return FWD_EX;
        else if (hit_mem) return FWD_MEM;
        else if (hit_wb)  return FWD_WB;
        else              return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp
//   Compares one ID source register against the EX, MEM and WB destinations.
//   Ports:
//     rs, used                 ID source register and its read enable
//     ex_rd/ex_we, mem_rd/mem_we, wb_rd/wb_we
//                              destination register and regfile write enable
//     hit_ex, hit_mem, hit_wb  source depends on that stage's result
// -----------------------------------------------------------------------------
module hazard_cmp
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       used,
    input  logic [4:0] ex_rd,
    input  logic       ex_we,
    input  logic [4:0] mem_rd,
    input  logic       mem_we,
    input  logic [4:0] wb_rd,
    input  logic       wb_we,
    output logic       hit_ex,
    output logic       hit_mem,
    output logic       hit_wb
);

    assign hit_ex  = reg_match(rs, used, ex_rd,  ex_we);
    assign hit_mem = reg_match(rs, used, mem_rd, mem_we);
    assign hit_wb  = reg_match(rs, used, wb_rd,  wb_we);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline controller for the 5-stage core. Detects RAW hazards between the
//   ID sources and the EX/MEM/WB destinations and drives forwarding selects,
//   PC / IF/ID stalls, ID/EX hold, and IF/ID + ID/EX flushes. Keeps saturating
//   counters of stall cycles and redirect flushes.
//   Configuration macro: HAZARD_FWD_EN
//     defined   : forwarding from EX/MEM/WB; only a load-use stalls (1 cycle)
//     undefined : no forwarding; any RAW match stalls until it clears
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     id_rs1/id_rs2, id_rs*_used     ID sources and read enables
//     ex_rd/ex_rf_we/ex_is_load      EX destination, write enable, load flag
//     mem_rd/mem_rf_we, wb_rd/wb_rf_we
//     ex_redirect                    taken branch / jump resolved in EX
//     mem_busy                       multi-cycle DRAM access in progress
//     pc_stall, ifid_stall, ifid_flush, idex_hold, idex_flush
//     fwd_a_sel, fwd_b_sel           operand source selects
//     stall_cnt, flush_cnt           saturating statistics
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_rf_we,
    input  logic             ex_is_load,
    input  logic [4:0]       mem_rd,
    input  logic             mem_rf_we,
    input  logic [4:0]       wb_rd,
    input  logic             wb_rf_we,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic a_ex, a_mem, a_wb;
    logic b_ex, b_mem, b_wb;

    hazard_cmp u_cmp_rs1 (
        .rs      (id_rs1),
        .used    (id_rs1_used),
        .ex_rd   (ex_rd),
        .ex_we   (ex_rf_we),
        .mem_rd  (mem_rd),
        .mem_we  (mem_rf_we),
        .wb_rd   (wb_rd),
        .wb_we   (wb_rf_we),
        .hit_ex  (a_ex),
        .hit_mem (a_mem),
        .hit_wb  (a_wb)
    );

    hazard_cmp u_cmp_rs2 (
        .rs      (id_rs2),
        .used    (id_rs2_used),
        .ex_rd   (ex_rd),
        .ex_we   (ex_rf_we),
        .mem_rd  (mem_rd),
        .mem_we  (mem_rf_we),
        .wb_rd   (wb_rd),
        .wb_we   (wb_rf_we),
        .hit_ex  (b_ex),
        .hit_mem (b_mem),
        .hit_wb  (b_wb)
    );

    state_e     state;
    state_e     state_next;
    logic       data_stall;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot forward in time; everything else is bypassed.
    assign data_stall = ex_is_load && (a_ex || b_ex);
    assign sel_a      = fwd_pick(a_ex, a_mem, a_wb);
    assign sel_b      = fwd_pick(b_ex, b_mem, b_wb);
`else
    // Without bypass paths the ID stage waits until every producer has retired.
    assign data_stall = a_ex || a_mem || a_wb || b_ex || b_mem || b_wb;
    assign sel_a      = FWD_RF;
    assign sel_b      = FWD_RF;

    logic unused_cfg;
    assign unused_cfg = ex_is_load ^ (state == ST_LU);
`endif

    // Outputs are forced quiet while reset is asserted, independent of the clock.
    assign fwd_a_sel = rst_n ? sel_a : FWD_RF;
    assign fwd_b_sel = rst_n ? sel_b : FWD_RF;

    // Priority: memory freeze > redirect flush > data-hazard stall.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_hold  = 1'b0;
        idex_flush = 1'b0;
        state_next = ST_RUN;
        if (!rst_n) begin
            state_next = ST_RUN;
        end else if (mem_busy) begin
            // Whole front end freezes; a pending redirect stays in EX and is
            // taken in the first cycle the memory releases.
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_hold  = 1'b1;
            state_next = ST_FRZ;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_next = ST_RUN;
        end else if (data_stall) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            state_next = ST_LU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (pc_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            // ifid_flush is only raised by a redirect that is actually taken.
            if (ifid_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

`ifdef HAZARD_FWD_EN
    // The bubble inserted by a load-use stall removes the load from EX, so the
    // same hazard seen again in LU_STALL means the EX stage ignored the flush.
    a_lu_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == ST_LU && data_stall && !mem_busy && !ex_redirect));
`endif

endmodule
